// File: rtl/rom_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// rom_arb_pkg: shared encodings and default sizes for the game-ROM arbiter
// Revision: 1.0
// ============================================================================
package rom_arb_pkg;

  localparam int NUM_REQ_MAX = 8;
  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_DATA_W  = 4;
  localparam int DEF_ROM_LAT = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rom_access_arbiter_rr_priority_pick.sv
`default_nettype none
// ============================================================================
// rr_priority_pick: first set request at or above ptr, wrapping modulo NUM_REQ
// Revision: 1.0
// ============================================================================
module rr_priority_pick
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_oh_o,
  output logic [PTR_W-1:0]   win_idx_o
);

  always_comb begin
    int   j;
    logic found;
    j         = 0;
    found     = 1'b0;
    win_oh_o  = '0;
    win_idx_o = '0;
    for (int i = 0; i < NUM_REQ_MAX; i++) begin
      if (i < NUM_REQ) begin
        j = int'(ptr_i) + i;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        if (!found && req_i[j]) begin
          found       = 1'b1;
          win_oh_o[j] = 1'b1;
          win_idx_o   = PTR_W'(j);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rom_access_arbiter.sv
`default_nettype none
// ============================================================================
// rom_access_arbiter: round-robin req/gnt/rd_valid front end for a shared synchronous ROM
// Revision: 1.0
// ============================================================================
module rom_access_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ROM_LAT = DEF_ROM_LAT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rd_valid_o,
  output logic [DATA_W-1:0]         rd_data_o,
  output logic [ADDR_W-1:0]         rom_addr_o,
  input  logic [DATA_W-1:0]         q_rom_i,
  output logic                      busy_o
);

  localparam int PTR_W = ptr_width(NUM_REQ);
  localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROM_LAT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  state_e               state_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [PTR_W-1:0]     owner_q;
  logic [NUM_REQ-1:0]   owner_oh_q;
  logic [CNT_W-1:0]     wait_cnt_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [NUM_REQ-1:0]   rd_valid_q;
  logic [DATA_W-1:0]    rd_data_q;
  logic [ADDR_W-1:0]    rom_addr_q;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [PTR_W-1:0]     pick_idx;
  logic [ADDR_W-1:0]    pick_addr;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i     (req_i),
    .ptr_i     (ptr_q),
    .win_oh_o  (pick_oh),
    .win_idx_o (pick_idx)
  );

  always_comb begin
    pick_addr = req_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
  end

  // Outputs are loaded on the edge entering the state in which they are visible,
  // so gnt shows during ADDR and rd_valid during DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      owner_oh_q <= '0;
      wait_cnt_q <= '0;
      gnt_q      <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      rom_addr_q <= '0;
    end else begin
      gnt_q      <= '0;
      rd_valid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|req_i) begin
            owner_q    <= pick_idx;
            owner_oh_q <= pick_oh;
            rom_addr_q <= pick_addr;
            gnt_q      <= pick_oh;
            state_q    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          wait_cnt_q <= '0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          if (wait_cnt_q == CNT_LAST) state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          rd_data_q  <= q_rom_i;
          rd_valid_q <= owner_oh_q;
          state_q    <= ST_DONE;
        end
        ST_DONE: begin
          ptr_q   <= (owner_q == PTR_LAST) ? '0 : owner_q + PTR_W'(1);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign rom_addr_o = rom_addr_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rom_access_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rom_access_arbiter: scoreboard bench for the shared-ROM arbiter
// Revision: 1.0
// ============================================================================
module tb_rom_access_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    gnt, rd_valid;
  logic [DW-1:0]   rd_data, q_rom;
  logic [AW-1:0]   rom_addr;
  logic            busy;

  logic [1:0]      xreq;
  logic [2*AW-1:0] xaddr;
  logic [1:0]      gnt1, rv1, gnt4, rv4;
  logic [DW-1:0]   data1, q1, data4, q4;
  logic [AW-1:0]   ra1, ra4;
  logic            busy1, busy4;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            gc;
    int            rc;
  } exp_t;
  exp_t sb[$];

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    logic [31:0] t;
    t = 32'(a) * 3 + 1;
    return t[DW-1:0];
  endfunction

  logic [DW-1:0] p2 [2];
  logic [DW-1:0] p1;
  logic [DW-1:0] p4 [4];
  always @(posedge clk) begin
    p2[0] <= rom_f(rom_addr);
    p2[1] <= p2[0];
    p1    <= rom_f(ra1);
    p4[0] <= rom_f(ra4);
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign q_rom = p2[1];
  assign q1    = p1;
  assign q4    = p4[3];

  rom_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(2)) u_dut (
    .clk(clk), .rst(rst), .req_i(req), .req_addr_i(req_addr), .gnt_o(gnt),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rom_addr_o(rom_addr),
    .q_rom_i(q_rom), .busy_o(busy)
  );

  rom_access_arbiter #(.NUM_REQ(2), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .req_i(xreq), .req_addr_i(xaddr), .gnt_o(gnt1),
    .rd_valid_o(rv1), .rd_data_o(data1), .rom_addr_o(ra1),
    .q_rom_i(q1), .busy_o(busy1)
  );

  rom_access_arbiter #(.NUM_REQ(2), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(4)) u_dut_l4 (
    .clk(clk), .rst(rst), .req_i(xreq), .req_addr_i(xaddr), .gnt_o(gnt4),
    .rd_valid_o(rv4), .rd_data_o(data4), .rom_addr_o(ra4),
    .q_rom_i(q4), .busy_o(busy4)
  );

  always @(negedge clk) begin
    if (!rst && (|gnt || |rd_valid)) begin
      checks++;
      if (!$onehot0(gnt) || !$onehot0(rd_valid) || (|gnt && |rd_valid)) begin
        errors++;
        $display("FAIL onehot_excl gnt=%b rd_valid=%b required one-hot and not both", gnt, rd_valid);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // Waits up to lim negedges for a grant (rv=0) or read-valid (rv=1); c=-1 on timeout.
  task automatic wait_out(input bit rv, input int lim, output int c,
                          output logic [N-1:0] v, output logic [DW-1:0] d,
                          output logic [AW-1:0] a);
    c = -1; v = '0; d = '0; a = '0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (rv ? |rd_valid : |gnt) begin
        c = cyc; v = rv ? rd_valid : gnt; d = rd_data; a = rom_addr;
        break;
      end
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1; req = '0; req_addr = '0; xreq = '0; xaddr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
  endtask

  task automatic push_exp(input int idx, input logic [AW-1:0] addr, input int gc);
    exp_t e;
    e = '{idx: idx, addr: addr, data: rom_f(addr), gc: gc, rc: gc + 4};
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 3'b111; req_addr = {5'h1F, 5'h1E, 5'h1D};
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, rd_valid, rd_data, rom_addr, busy} !== '0) begin
      errors++;
      $display("FAIL reset_state gnt=%b rv=%b data=%h addr=%h busy=%b required all 0",
               gnt, rd_valid, rd_data, rom_addr, busy);
    end
    reset_dut();
  endtask

  task automatic test_single();
    int c; logic [N-1:0] v; logic [DW-1:0] d; logic [AW-1:0] a; exp_t e;
    reset_dut();
    push_exp(0, 5'h03, cyc + 1);
    req = 3'b001; req_addr[4:0] = 5'h03;
    wait_out(0, 20, c, v, d, a);
    req = '0;
    e = sb[0];
    checks++;
    if (c !== e.gc || v !== N'(1 << e.idx) || a !== e.addr) begin
      errors++;
      $display("FAIL single_gnt cyc=%0d gnt=%b addr=%h required cyc=%0d gnt=%b addr=%h",
               c, v, a, e.gc, N'(1 << e.idx), e.addr);
    end
    wait_out(1, 20, c, v, d, a);
    e = sb.pop_front();
    checks++;
    if (c !== e.rc || v !== N'(1 << e.idx) || d !== 4'hA || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_rv cyc=%0d rv=%b data=%h busy=%b required cyc=%0d rv=%b data=a busy=1",
               c, v, d, busy, e.rc, N'(1 << e.idx));
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle busy=%b required 0", busy);
    end
  endtask

  // Shared by the multi-transaction scenarios: pops one grant and one read per entry.
  task automatic drain(input string name, input int n_drop);
    int c; logic [N-1:0] v; logic [DW-1:0] d; logic [AW-1:0] a; exp_t e;
    for (int i = 0; i < n_drop; i++) begin
      e = sb[0];
      wait_out(0, 30, c, v, d, a);
      if (i == n_drop - 1) req = '0;
      checks++;
      if (c !== e.gc || v !== N'(1 << e.idx) || a !== e.addr) begin
        errors++;
        $display("FAIL %s_gnt%0d cyc=%0d gnt=%b addr=%h required cyc=%0d gnt=%b addr=%h",
                 name, i, c, v, a, e.gc, N'(1 << e.idx), e.addr);
      end
      wait_out(1, 30, c, v, d, a);
      e = sb.pop_front();
      checks++;
      if (c !== e.rc || v !== N'(1 << e.idx) || d !== e.data) begin
        errors++;
        $display("FAIL %s_rv%0d cyc=%0d rv=%b data=%h required cyc=%0d rv=%b data=%h",
                 name, i, c, v, d, e.rc, N'(1 << e.idx), e.data);
      end
    end
  endtask

  task automatic test_round_robin();
    int k;
    reset_dut();
    k = cyc;
    req = 3'b111; req_addr = {5'h1F, 5'h02, 5'h01};
    push_exp(0, 5'h01, k + 1);
    push_exp(1, 5'h02, k + 7);
    push_exp(2, 5'h1F, k + 13);
    push_exp(0, 5'h01, k + 19);
    drain("rr", 4);
  endtask

  task automatic test_withdraw();
    int c, k; logic [N-1:0] v; logic [DW-1:0] d; logic [AW-1:0] a; exp_t e;
    reset_dut();
    k = cyc;
    push_exp(0, 5'h04, k + 1);
    req = 3'b001; req_addr = {5'h07, 5'h06, 5'h04};
    wait_out(0, 20, c, v, d, a);
    e = sb[0];
    checks++;
    if (c !== e.gc || v !== 3'b001) begin
      errors++;
      $display("FAIL wd_gnt0 cyc=%0d gnt=%b required cyc=%0d gnt=001", c, v, e.gc);
    end
    req = 3'b110;
    push_exp(2, 5'h07, k + 7);
    repeat (2) @(negedge clk);
    req[1] = 1'b0;
    wait_out(1, 20, c, v, d, a);
    e = sb.pop_front();
    checks++;
    if (c !== e.rc || v !== 3'b001 || d !== e.data) begin
      errors++;
      $display("FAIL wd_rv0 cyc=%0d rv=%b data=%h required cyc=%0d rv=001 data=%h",
               c, v, d, e.rc, e.data);
    end
    drain("wd", 1);
    wait_out(1, 15, c, v, d, a);
    checks++;
    if (c !== -1) begin
      errors++;
      $display("FAIL wd_no_rv1 rv=%b at cyc=%0d required no further rd_valid", v, c);
    end
  endtask

  task automatic test_addr_change();
    int c; logic [N-1:0] v; logic [DW-1:0] d; logic [AW-1:0] a; exp_t e;
    reset_dut();
    push_exp(0, 5'h0A, cyc + 1);
    req = 3'b001; req_addr[4:0] = 5'h0A;
    wait_out(0, 20, c, v, d, a);
    req = '0;
    @(negedge clk);
    req_addr[4:0] = 5'h1F;
    wait_out(1, 20, c, v, d, a);
    e = sb.pop_front();
    checks++;
    if (c !== e.rc || d !== e.data || a !== 5'h0A) begin
      errors++;
      $display("FAIL addr_change cyc=%0d data=%h rom_addr=%h required cyc=%0d data=%h rom_addr=0a",
               c, d, a, e.rc, e.data);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    reset_dut();
    k = cyc;
    req = 3'b001; req_addr[4:0] = 5'h1F;
    for (int i = 0; i < 3; i++) push_exp(0, 5'h1F, k + 1 + 6 * i);
    drain("b2b", 3);
  endtask

  task automatic test_reset_mid();
    int c, k; logic [N-1:0] v; logic [DW-1:0] d; logic [AW-1:0] a;
    reset_dut();
    push_exp(0, 5'h06, cyc + 1);
    req = 3'b001; req_addr = {5'h00, 5'h09, 5'h06};
    drain("pre", 1);
    @(posedge clk); #1;
    k = cyc;
    req = 3'b010;
    wait_out(0, 20, c, v, d, a);
    req = '0;
    checks++;
    if (c !== k + 1 || v !== 3'b010) begin
      errors++;
      $display("FAIL mid_gnt cyc=%0d gnt=%b required cyc=%0d gnt=010", c, v, k + 1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt, rd_valid, rd_data, rom_addr, busy} !== '0) begin
      errors++;
      $display("FAIL mid_reset gnt=%b rv=%b data=%h addr=%h busy=%b required all 0",
               gnt, rd_valid, rd_data, rom_addr, busy);
    end
    rst = 1'b0;
    wait_out(1, 12, c, v, d, a);
    checks++;
    if (c !== -1) begin
      errors++;
      $display("FAIL mid_no_rv rv=%b at cyc=%0d required none", v, c);
    end
    req_addr[4:0] = 5'h02;
    push_exp(0, 5'h02, cyc + 1);
    req = 3'b011;
    drain("mid_ptr", 1);
  endtask

  task automatic test_latency();
    int k, g1, g4, r1, r4;
    logic [DW-1:0] d1, d4;
    reset_dut();
    g1 = -1; g4 = -1; r1 = -1; r4 = -1; d1 = '0; d4 = '0;
    k = cyc;
    xreq = 2'b01; xaddr[4:0] = 5'h0B;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (|gnt1 && g1 < 0) g1 = cyc;
      if (|gnt4 && g4 < 0) g4 = cyc;
      if (g1 >= 0 && g4 >= 0) xreq = '0;
      if (|rv1 && r1 < 0) begin r1 = cyc; d1 = data1; end
      if (|rv4 && r4 < 0) begin r4 = cyc; d4 = data4; end
    end
    checks++;
    if (g1 !== k + 1 || r1 !== k + 4 || d1 !== rom_f(5'h0B)) begin
      errors++;
      $display("FAIL lat1 gnt=%0d rv=%0d data=%h required gnt=%0d rv=%0d data=%h",
               g1, r1, d1, k + 1, k + 4, rom_f(5'h0B));
    end
    checks++;
    if (g4 !== k + 1 || r4 !== k + 7 || d4 !== rom_f(5'h0B)) begin
      errors++;
      $display("FAIL lat4 gnt=%0d rv=%0d data=%h required gnt=%0d rv=%0d data=%h",
               g4, r4, d4, k + 1, k + 7, rom_f(5'h0B));
    end
  endtask

  initial begin
    req = '0; req_addr = '0; xreq = '0; xaddr = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_withdraw();
    test_addr_change();
    test_back_to_back();
    test_reset_mid();
    test_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
